time_set_ctrl: RTL and testbench

//  Single-clock sequencer for the digital-clock hour/minute/second counter datapath.

---
 rtl/time_set_ctrl_pkg.sv | 19 +
 rtl/time_set_ctrl_btn_debounce.sv | 55 +++++
 rtl/time_set_ctrl.sv | 137 +++++++++++++
 tb/tb_time_set_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared mode encoding, default timing constants and a width helper for the
// digital-clock time-set sequencer.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10
    } mode_t;

    localparam int TICK_DIV_DEFAULT  = 50_000_000;
    localparam int DB_CYCLES_DEFAULT = 1_000_000;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce
    import time_set_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int DW = cnt_width(DB_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          pulse_r;
    logic [DW-1:0] cnt_r;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // The level only follows the input after DB_CYCLES consecutive disagreeing
    // samples; any return to agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= 1'b0;
            pulse_r <= 1'b0;
            cnt_r   <= '0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= '0;
            pulse_r <= 1'b0;
        end else if (cnt_r == DW'(DB_CYCLES - 1)) begin
            level_r <= sync2_r;
            cnt_r   <= '0;
            pulse_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + DW'(1);
            pulse_r <= 1'b0;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Sequencer for the hour/minute/second counters: 1 Hz prescaler, RUN/SET_H/SET_M
// mode FSM, registered count enables and display blink qualifiers.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       s_tc,
    input  logic       m_tc,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink_h,
    output logic       blink_m
);

    localparam int CW = cnt_width(TICK_DIV);

    logic          mode_p_s;
    logic          inc_p_s;
    logic          tick_s;
    logic          half_s;
    logic          leave_s;
    logic          phase_next_s;
    mode_t         state_next_s;

    logic [CW-1:0] presc_r;
    logic          phase_r;
    mode_t         state_r;
    logic          sec_tick_r;
    logic          min_tick_r;
    logic          hour_tick_r;
    logic          sec_clr_r;
    logic          blink_h_r;
    logic          blink_m_r;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .pulse (mode_p_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .pulse (inc_p_s)
    );

    assign tick_s       = (presc_r == CW'(TICK_DIV - 1));
    assign half_s       = (presc_r == CW'(TICK_DIV / 2 - 1));
    assign leave_s      = (state_r == MODE_SET_M) & mode_p_s;
    assign phase_next_s = phase_r ^ (tick_s | half_s);

    // Mode sequence advances only on a debounced mode press.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MODE_RUN:   state_next_s = mode_p_s ? MODE_SET_H : MODE_RUN;
            MODE_SET_H: state_next_s = mode_p_s ? MODE_SET_M : MODE_SET_H;
            MODE_SET_M: state_next_s = mode_p_s ? MODE_RUN   : MODE_SET_M;
            default:    state_next_s = MODE_RUN;
        endcase
    end

    // Prescaler and blink phase; leaving SET_M restarts the second so the
    // first full second begins together with the seconds clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= '0;
            phase_r <= 1'b0;
        end else begin
            if (leave_s || tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + CW'(1);
            end
            phase_r <= phase_next_s;
        end
    end

    // State register and all output enables; outputs reflect the state that
    // was current when the tick or press arrived.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= MODE_RUN;
            sec_tick_r  <= 1'b0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            sec_clr_r   <= 1'b0;
            blink_h_r   <= 1'b0;
            blink_m_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            sec_tick_r  <= 1'b0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            sec_clr_r   <= 1'b0;
            case (state_r)
                MODE_RUN: begin
                    sec_tick_r  <= tick_s;
                    min_tick_r  <= tick_s & s_tc;
                    hour_tick_r <= tick_s & s_tc & m_tc;
                end
                MODE_SET_H: begin
                    hour_tick_r <= inc_p_s & ~mode_p_s;
                end
                MODE_SET_M: begin
                    min_tick_r <= inc_p_s & ~mode_p_s;
                    sec_clr_r  <= mode_p_s;
                end
                default: begin
                    sec_clr_r <= 1'b0;
                end
            endcase
            blink_h_r <= (state_next_s == MODE_SET_H) & phase_next_s;
            blink_m_r <= (state_next_s == MODE_SET_M) & phase_next_s;
        end
    end

    assign sec_tick  = sec_tick_r;
    assign min_tick  = min_tick_r;
    assign hour_tick = hour_tick_r;
    assign sec_clr   = sec_clr_r;
    assign mode      = state_r;
    assign blink_h   = blink_h_r;
    assign blink_m   = blink_m_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed scenarios followed by random
// button presses, checked against a cycle-level behavioural model.
module tb_time_set_ctrl;

    localparam int TD = 4;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       s_tc = 1'b0;
    logic       m_tc = 1'b0;
    logic       sec_tick, min_tick, hour_tick, sec_clr, blink_h, blink_m;
    logic [1:0] mode;

    time_set_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .s_tc      (s_tc),
        .m_tc      (m_tc),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .hour_tick (hour_tick),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink_h   (blink_h),
        .blink_m   (blink_m)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit sec; bit mn; bit hr; bit clr; } evt_t;
    typedef struct { int cyc; int md; bit bh; bit bm; } st_t;

    evt_t evt_q[$];
    st_t  st_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // behavioural model state: mode 0=RUN 1=SET_H 2=SET_M, position in second
    int   m_md, m_pos, run_m, run_i;
    bit   m_ph;
    int   mode_due[$];
    int   inc_due[$];
    bit   rnd_tc = 1'b0;

    // observation counters kept by the monitor
    int   sec_seen = 0, min_seen = 0, hour_seen = 0, clr_seen = 0;
    int   last_clr = -1, clr_gap = -1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_init();
        m_md = 0; m_pos = 0; m_ph = 1'b0; run_m = 0; run_i = 0;
        mode_due.delete();
        inc_due.delete();
    endfunction

    // One clock edge of the reference: a button held DB samples becomes a
    // press acted on three edges later; tick is the last cycle of a second.
    function automatic void model_step();
        bit mp, ip, tick, half, sec, mn, hr, clr;
        int nmd;
        evt_t e;
        st_t  s;
        cyc++;
        run_m = btn_mode ? run_m + 1 : 0;
        run_i = btn_inc  ? run_i + 1 : 0;
        if (run_m == DB) mode_due.push_back(cyc + 3);
        if (run_i == DB) inc_due.push_back(cyc + 3);
        mp = 1'b0; ip = 1'b0;
        if (mode_due.size() > 0 && mode_due[0] == cyc) begin mp = 1'b1; void'(mode_due.pop_front()); end
        if (inc_due.size() > 0 && inc_due[0] == cyc) begin ip = 1'b1; void'(inc_due.pop_front()); end
        tick = (m_pos == TD - 1);
        half = (m_pos == TD / 2 - 1);
        sec = 1'b0; mn = 1'b0; hr = 1'b0; clr = 1'b0;
        nmd = m_md;
        if (m_md == 0) begin
            sec = tick; mn = tick && s_tc; hr = tick && s_tc && m_tc;
            if (mp) nmd = 1;
        end else if (m_md == 1) begin
            hr = ip && !mp;
            if (mp) nmd = 2;
        end else begin
            mn = ip && !mp; clr = mp;
            if (mp) nmd = 0;
        end
        m_pos = (clr || tick) ? 0 : m_pos + 1;
        if (tick || half) m_ph = !m_ph;
        m_md = nmd;
        s.cyc = cyc; s.md = m_md; s.bh = (m_md == 1) && m_ph; s.bm = (m_md == 2) && m_ph;
        st_q.push_back(s);
        if (sec || mn || hr || clr) begin
            e.cyc = cyc; e.sec = sec; e.mn = mn; e.hr = hr; e.clr = clr;
            evt_q.push_back(e);
        end
    endfunction

    // Monitor: pops an expected event whenever the DUT pulses any enable, and
    // one status entry per modelled clock edge.
    always @(negedge clk) begin
        if (sec_tick || min_tick || hour_tick || sec_clr) begin
            if (sec_tick)  sec_seen++;
            if (min_tick)  min_seen++;
            if (hour_tick) hour_seen++;
            if (sec_clr) begin clr_seen++; last_clr = cyc; end
            if (sec_tick && last_clr >= 0 && clr_gap < 0) clr_gap = cyc - last_clr;
            if (evt_q.size() == 0) begin
                check("unexpected_pulse", int'({sec_tick, min_tick, hour_tick, sec_clr}), 0);
            end else begin
                evt_t e;
                e = evt_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_bits", int'({sec_tick, min_tick, hour_tick, sec_clr}),
                      int'({e.sec, e.mn, e.hr, e.clr}));
            end
        end
        if (st_q.size() > 0) begin
            st_t s;
            s = st_q.pop_front();
            check("mode", int'(mode), s.md);
            check("blink", int'({blink_h, blink_m}), int'({s.bh, s.bm}));
        end
    end

    task automatic cyc_t();
        if (rnd_tc) begin
            s_tc = ($urandom_range(0, 1) == 1);
            m_tc = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press(bit m, bit i, int len, int gap);
        btn_mode = m;
        btn_inc  = i;
        repeat (len) cyc_t();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (gap) cyc_t();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_outputs",
              int'({sec_tick, min_tick, hour_tick, sec_clr, mode, blink_h, blink_m}), 0);
        check("events_pending_at_reset", evt_q.size(), 0);
        evt_q.delete();
        st_q.delete();
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, s0;
        model_init();
        #1 reset = 1'b1;
        #2;
        check("reset_state",
              int'({sec_tick, min_tick, hour_tick, sec_clr, mode, blink_h, blink_m}), 0);
        @(negedge clk);
        #2 reset = 1'b0;

        // 1: free-running seconds
        s0 = sec_seen;
        repeat (12) cyc_t();
        settle();
        check("run_sec_pulses", sec_seen - s0, 3);
        check("run_no_min", min_seen, 0);

        // 2: full carry chain
        s_tc = 1'b1; m_tc = 1'b1;
        repeat (4) cyc_t();
        settle();
        check("carry_hour", hour_seen, 1);
        s_tc = 1'b0; m_tc = 1'b0;

        // 3: SET_H with three increments
        press(1'b1, 1'b0, DB + 1, DB + 5);
        check("mode_set_h", int'(mode), 1);
        h0 = hour_seen; s0 = sec_seen;
        repeat (3) press(1'b0, 1'b1, DB + 1, DB + 4);
        settle();
        check("set_h_hour_pulses", hour_seen - h0, 3);
        check("set_h_no_sec", sec_seen - s0, 0);

        // 4: SET_M increment with m_tc high, then return to RUN
        press(1'b1, 1'b0, DB + 1, DB + 5);
        m_tc = 1'b1;
        h0 = hour_seen; s0 = min_seen;
        press(1'b0, 1'b1, DB + 1, DB + 4);
        settle();
        check("set_m_min_pulse", min_seen - s0, 1);
        check("set_m_no_hour", hour_seen - h0, 0);
        m_tc = 1'b0;
        press(1'b1, 1'b0, DB + 1, DB + 8);
        settle();
        check("back_to_run", int'(mode), 0);
        check("sec_clr_count", clr_seen, 1);
        check("clr_to_sec_gap", clr_gap, TD);

        // 5: simultaneous presses, then a short bounce
        h0 = hour_seen;
        press(1'b1, 1'b1, DB + 1, DB + 5);
        check("mode_wins", int'(mode), 1);
        check("mode_wins_no_hour", hour_seen - h0, 0);
        press(1'b0, 1'b1, 1, DB + 6);
        settle();
        check("bounce_no_hour", hour_seen - h0, 0);

        // 6: reset during SET_H with increment held
        btn_inc = 1'b1;
        repeat (2) cyc_t();
        h0 = hour_seen;
        apply_reset();
        repeat (DB + 8) cyc_t();
        btn_inc = 1'b0;
        repeat (DB + 4) cyc_t();
        settle();
        check("post_reset_mode", int'(mode), 0);
        check("post_reset_no_hour", hour_seen - h0, 0);

        // random presses with random terminal-count flags
        rnd_tc = 1'b1;
        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)
                press(1'b1, 1'b0, DB + $urandom_range(0, 3), DB + 3 + $urandom_range(0, 5));
            else if (r < 7)
                press(1'b0, 1'b1, DB + $urandom_range(0, 3), DB + 3 + $urandom_range(0, 5));
            else if (r < 8)
                press(1'b1, 1'b1, DB + $urandom_range(0, 3), DB + 3 + $urandom_range(0, 5));
            else if (r < 9)
                press(1'b0, 1'b1, 1, DB + 3 + $urandom_range(0, 5));
            else
                repeat ($urandom_range(1, 9)) cyc_t();
        end
        rnd_tc = 1'b0;
        repeat (8) cyc_t();
        settle();
        check("events_drained", evt_q.size(), 0);
        check("status_drained", st_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
